apb_rr_arbiter: RTL and testbench
=================================

Name: apb_rr_arbiter

Overview:
Two-requester front end that shares one APB bus, issuing transfers from two independent requester ports. Round-robin arbitration picks the requester. The block sequences the APB SETUP and ACCESS phases, honours PREADY wait states, and returns read data and error to the granted requester. A programmable watchdog aborts transfers when the slave stalls PREADY low.

Parameters:
ADDR_W, 32, APB address width
DATA_W, 32, APB data width; must be a multiple of 8
TIMEOUT, 16, maximum ACCESS-phase cycles before abort; 0 disables the watchdog

Ports:
PCLK  in  1  clock, rising edge
PRESETn  in  1  asynchronous active-low reset
req_valid  in  2  per-requester request; held high until its done pulse
req_write  in  2  per-requester direction, 1 = write
req_addr0  in  ADDR_W  requester 0 address
req_addr1  in  ADDR_W  requester 1 address
req_wdata0  in  DATA_W  requester 0 write data
req_wdata1  in  DATA_W  requester 1 write data
req_done  out  2  one-cycle completion pulse, one-hot
rsp_rdata  out  DATA_W  read data; valid while req_done is nonzero
rsp_err  out  1  error flag; valid while req_done is nonzero
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_W  APB address
PWDATA  out  DATA_W  APB write data
PSTRB  out  DATA_W/8  APB write strobes
PREADY  in  1  slave ready
PRDATA  in  DATA_W  slave read data
PSLVERR  in  1  slave error

Behaviour:
- Reset (async, PRESETn=0):
  - all outputs 0; state IDLE.
  - last_grant=1, so requester 0 wins the first contention.
  - watchdog count 0.
  - Effective immediately mid-transfer: PSEL and PENABLE drop without completion; no req_done is issued.
- Requester rule: addr, wdata and write are stable while req_valid is high, until req_done. The requester drops req_valid the cycle after req_done, or keeps it high to issue a new request.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - Eligible requesters = req_valid & ~req_done. A requester whose done is asserted this cycle is masked.
  - If one is eligible: grant it.
  - If both are eligible: grant the one not equal to last_grant.
  - On grant: register PADDR, PWDATA and PWRITE from the winner; PSEL=1, PENABLE=0; go to SETUP.
  - PSTRB = all ones for writes, 0 for reads.
- SETUP: PENABLE=1; clear the watchdog; go to ACCESS.
- ACCESS, PREADY=1:
  - Complete: req_done[grant]=1 for exactly one cycle.
  - rsp_rdata = PRDATA for reads, 0 for writes.
  - rsp_err = PSLVERR.
  - PSEL, PENABLE and PSTRB return to 0; last_grant=grant; go to IDLE.
- ACCESS, PREADY=0: increment the watchdog.
  - If TIMEOUT!=0 and the count reaches TIMEOUT-1 with PREADY still 0: complete as above with rsp_err=1 and rsp_rdata=0.
- PREADY=1 in the same cycle the watchdog expires: PREADY wins; rsp_err = PSLVERR.
- Latency, zero wait states: valid sampled in IDLE at edge n; SETUP at n+1; ACCESS at n+2; done visible after edge n+3.
- Back-to-back: at least one IDLE cycle between transfers, in which that cycle's done is asserted. PSEL deasserts between transfers.
- rsp_rdata and rsp_err hold their values until the next completion; only req_done qualifies them.
- PADDR, PWDATA and PWRITE stay stable from SETUP through the last ACCESS cycle.
- Watchdog counter width: $clog2(TIMEOUT+1); saturates and never wraps.

Decomposition:
- Package apb_pkg:
  - state enum (IDLE, SETUP, ACCESS)
  - default ADDR_W and DATA_W
  - strobe-width function
- One sub-module, rr_arbiter_2:
  - inputs: eligible vector and last_grant
  - output: combinational one-hot grant
  - pointer update stays in the parent.

Test Plan:
- Req0 write, addr 0x10, data 0xDEADBEEF, PREADY tied 1 → PSEL rises after edge 1, PENABLE after edge 2, PSTRB=4'hF, req_done=2'b01 after edge 3, rsp_err=0.
- Req1 read, addr 0x20; slave holds PREADY=0 for 3 ACCESS cycles, then PRDATA=32'd25 → PENABLE high for 4 cycles, PSTRB=0, req_done=2'b10 with rsp_rdata=25.
- Both requests valid at reset exit, held continuously → grant order 0,1,0,1; PSEL low for one IDLE cycle between transfers.
- TIMEOUT=16, PREADY stuck 0 → done pulses on the 16th ACCESS cycle with rsp_err=1 and rsp_rdata=0. Repeat with PREADY=1 on the 16th cycle → rsp_err = PSLVERR.
- Write with PSLVERR=1 at the PREADY cycle → rsp_err=1; the next transfer's rsp_err=0.
- PRESETn pulsed low during ACCESS → PSEL, PENABLE and req_done are 0 immediately, with no done pulse. After release with req_valid=2'b11 → requester 0 is granted first.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared definitions for the two-requester APB front end.
//   - default APB address/data widths
//   - FSM state encoding (plain localparams plus an enum built on them)
//   - strb_width(): number of byte strobes for a given data width
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        SETUP  = ST_SETUP,
        ACCESS = ST_ACCESS
    } apb_state_e;

    function automatic int strb_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant logic (purely combinational).
//   eligible   : requesters currently allowed to compete
//   last_grant : index of the requester served most recently
//   grant      : one-hot winner, zero when nobody is eligible
// The pointer itself lives in the parent; this block only decides.
module rr_arbiter_2 (
    input  logic [1:0] eligible,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = eligible;
        // On contention the requester that was not served last wins.
        if (eligible == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/apb_rr_arbiter.sv
// Two-requester APB master with round-robin arbitration and a PREADY
// watchdog.
//   PCLK, PRESETn          : clock (rising edge), async active-low reset
//   req_valid/req_write    : per-requester request and direction
//   req_addr0/1, wdata0/1  : per-requester address and write data
//   req_done               : one-cycle one-hot completion pulse
//   rsp_rdata, rsp_err     : response, qualified by req_done, held otherwise
//   PSEL..PSTRB            : APB master outputs
//   PREADY, PRDATA, PSLVERR: APB slave inputs
//
// Requester handshake: a requester raises req_valid[i] with stable
// addr/wdata/write and keeps everything stable until req_done[i] pulses.
// req_done[i] is the only acceptance/completion event; there is no separate
// ready. During the done cycle the requester is masked from arbitration, so
// it may either drop req_valid in the following cycle or keep it high to
// issue another request.
module apb_rr_arbiter
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic                          PCLK,
    input  logic                          PRESETn,
    input  logic [1:0]                    req_valid,
    input  logic [1:0]                    req_write,
    input  logic [ADDR_W-1:0]             req_addr0,
    input  logic [ADDR_W-1:0]             req_addr1,
    input  logic [DATA_W-1:0]             req_wdata0,
    input  logic [DATA_W-1:0]             req_wdata1,
    output logic [1:0]                    req_done,
    output logic [DATA_W-1:0]             rsp_rdata,
    output logic                          rsp_err,
    output logic                          PSEL,
    output logic                          PENABLE,
    output logic                          PWRITE,
    output logic [ADDR_W-1:0]             PADDR,
    output logic [DATA_W-1:0]             PWDATA,
    output logic [strb_width(DATA_W)-1:0] PSTRB,
    input  logic                          PREADY,
    input  logic [DATA_W-1:0]             PRDATA,
    input  logic                          PSLVERR
);

    // Watchdog width keeps at least one bit so TIMEOUT=0 still elaborates.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] WD_SAT  = {CNT_W{1'b1}};

    apb_state_e       state;
    logic             last_grant;
    logic             grant_idx;
    logic [CNT_W-1:0] wd_cnt;

    logic [1:0]       eligible;
    logic [1:0]       grant;
    logic             win_sel;
    logic             wd_expire;
    logic             complete;

    // A requester completing this cycle must not be re-granted the same
    // request before it has had a chance to withdraw or renew it.
    assign eligible = req_valid & ~req_done;

    rr_arbiter_2 u_rr_arbiter_2 (
        .eligible   (eligible),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign win_sel   = grant[1];
    // PREADY has priority over expiry: expiry only fires while PREADY is low.
    assign wd_expire = (TIMEOUT != 0) && !PREADY && (wd_cnt == WD_LAST);
    assign complete  = PREADY || wd_expire;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_idx  <= 1'b0;
            wd_cnt     <= '0;
            req_done   <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
            PSTRB      <= '0;
        end else begin
            req_done <= '0;
            case (state)
                IDLE: begin
                    if (|grant) begin
                        grant_idx <= win_sel;
                        PADDR     <= win_sel ? req_addr1 : req_addr0;
                        PWDATA    <= win_sel ? req_wdata1 : req_wdata0;
                        PWRITE    <= req_write[win_sel];
                        PSTRB     <= req_write[win_sel] ? '1 : '0;
                        PSEL      <= 1'b1;
                        PENABLE   <= 1'b0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    wd_cnt  <= '0;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (complete) begin
                        req_done   <= grant_idx ? 2'b10 : 2'b01;
                        rsp_rdata  <= (PREADY && !PWRITE) ? PRDATA : '0;
                        rsp_err    <= PREADY ? PSLVERR : 1'b1;
                        PSEL       <= 1'b0;
                        PENABLE    <= 1'b0;
                        PSTRB      <= '0;
                        last_grant <= grant_idx;
                        state      <= IDLE;
                    end else if (wd_cnt != WD_SAT) begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed + randomized bench for apb_rr_arbiter. The bench plays both
// requesters and the APB slave. Expected values come from a transaction-level
// model: ACCESS length = waits+1 unless waits >= TIMEOUT (then TIMEOUT cycles
// and an error), contention goes to the requester not served last.
module tb_apb_rr_arbiter;

    localparam int TIMEOUT = 16;

    logic        PCLK;
    logic        PRESETn;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [31:0] req_addr0;
    logic [31:0] req_addr1;
    logic [31:0] req_wdata0;
    logic [31:0] req_wdata1;
    logic [1:0]  req_done;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;

    apb_rr_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr0  (req_addr0),
        .req_addr1  (req_addr1),
        .req_wdata0 (req_wdata0),
        .req_wdata1 (req_wdata1),
        .req_done   (req_done),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PSTRB      (PSTRB),
        .PREADY     (PREADY),
        .PRDATA     (PRDATA),
        .PSLVERR    (PSLVERR)
    );

    // ---------------- clock / reset ----------------
    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench did not finish in time");
        $fatal(1, "bench time limit reached");
    end

    // ---------------- model / scoreboard state ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [32:0] exp_q[$];      // {err, rdata} per granted transfer
    logic [32:0] last_rsp;      // response the DUT must keep holding
    bit          mdl_last;      // requester served most recently

    bit          p_wr    [2];
    logic [31:0] p_addr  [2];
    logic [31:0] p_wdata [2];
    int          p_waits [2];
    logic [31:0] p_rd    [2];
    bit          p_serr  [2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_req(input int id, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int waits,
                           input logic [31:0] rd, input bit serr);
        p_wr[id]    = wr;
        p_addr[id]  = addr;
        p_wdata[id] = wdata;
        p_waits[id] = waits;
        p_rd[id]    = rd;
        p_serr[id]  = serr;
    endtask

    task automatic rand_req(input int id);
        int w;
        w = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 20))
                                        : int'($urandom_range(0, 3));
        set_req(id, 1'($urandom_range(0, 1)), $urandom, $urandom, w, $urandom,
                1'($urandom_range(0, 1)));
    endtask

    task automatic present(input int id);
        req_write[id] = p_wr[id];
        if (id == 0) begin
            req_addr0  = p_addr[0];
            req_wdata0 = p_wdata[0];
        end else begin
            req_addr1  = p_addr[1];
            req_wdata1 = p_wdata[1];
        end
        req_valid[id] = 1'b1;
    endtask

    // Entered at the negedge of the SETUP cycle for requester id; returns at
    // the negedge of the cycle that carries its done pulse.
    task automatic run_xfer(input int id);
        bit          to;
        int          n_acc;
        logic [32:0] exp_rsp;
        to      = (TIMEOUT != 0) && (p_waits[id] >= TIMEOUT);
        n_acc   = to ? TIMEOUT : p_waits[id] + 1;
        exp_rsp = {(to ? 1'b1 : p_serr[id]), ((to || p_wr[id]) ? 32'h0 : p_rd[id])};
        exp_q.push_back(exp_rsp);

        check("setup_psel", 64'(PSEL), 64'd1);
        check("setup_penable", 64'(PENABLE), 64'd0);
        check("setup_paddr", 64'(PADDR), 64'(p_addr[id]));
        check("setup_pwrite", 64'(PWRITE), 64'(p_wr[id]));
        check("setup_pstrb", 64'(PSTRB), p_wr[id] ? 64'hF : 64'h0);
        if (p_wr[id]) check("setup_pwdata", 64'(PWDATA), 64'(p_wdata[id]));
        check("setup_done", 64'(req_done), 64'd0);

        for (int k = 1; k <= n_acc; k++) begin
            @(negedge PCLK);
            check("access_psel", 64'(PSEL), 64'd1);
            check("access_penable", 64'(PENABLE), 64'd1);
            check("access_paddr", 64'(PADDR), 64'(p_addr[id]));
            check("access_done", 64'(req_done), 64'd0);
            if (k > p_waits[id]) begin
                PREADY  = 1'b1;
                PRDATA  = p_rd[id];
                PSLVERR = p_serr[id];
            end else begin
                PREADY  = 1'b0;
                PRDATA  = $urandom;
                PSLVERR = 1'($urandom_range(0, 1));
            end
        end

        @(negedge PCLK);
        PREADY  = 1'b0;
        PRDATA  = $urandom;
        PSLVERR = 1'b0;
        exp_rsp = exp_q.pop_front();
        check("done_onehot", 64'(req_done), (id == 1) ? 64'd2 : 64'd1);
        check("done_rdata", 64'(rsp_rdata), 64'(exp_rsp[31:0]));
        check("done_err", 64'(rsp_err), 64'(exp_rsp[32]));
        check("done_psel", 64'(PSEL), 64'd0);
        check("done_penable", 64'(PENABLE), 64'd0);
        check("done_pstrb", 64'(PSTRB), 64'd0);
        last_rsp = exp_rsp;
        mdl_last = (id == 1);
    endtask

    // Drop the request in the cycle after its done pulse.
    task automatic release_req(input int id);
        @(posedge PCLK);
        #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic idle_check();
        check("idle_psel", 64'(PSEL), 64'd0);
        check("idle_done", 64'(req_done), 64'd0);
        check("idle_rdata_hold", 64'(rsp_rdata), 64'(last_rsp[31:0]));
        check("idle_err_hold", 64'(rsp_err), 64'(last_rsp[32]));
    endtask

    task automatic single(input int id);
        present(id);
        @(negedge PCLK);
        run_xfer(id);
        release_req(id);
        @(negedge PCLK);
        idle_check();
    endtask

    // Both requests presented together; the winner is whoever was not last.
    task automatic pair_flow();
        int w;
        present(0);
        present(1);
        w = mdl_last ? 0 : 1;
        @(negedge PCLK);
        run_xfer(w);
        release_req(w);
        @(negedge PCLK);
        run_xfer(1 - w);
        release_req(1 - w);
        @(negedge PCLK);
        idle_check();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        PRESETn    = 1'b0;
        req_valid  = 2'b00;
        req_write  = 2'b00;
        req_addr0  = '0;
        req_addr1  = '0;
        req_wdata0 = '0;
        req_wdata1 = '0;
        PREADY     = 1'b0;
        PRDATA     = '0;
        PSLVERR    = 1'b0;
        mdl_last   = 1'b1;
        last_rsp   = '0;

        // reset values
        #12;
        check("rst_psel", 64'(PSEL), 64'd0);
        check("rst_penable", 64'(PENABLE), 64'd0);
        check("rst_pwrite", 64'(PWRITE), 64'd0);
        check("rst_paddr", 64'(PADDR), 64'd0);
        check("rst_pwdata", 64'(PWDATA), 64'd0);
        check("rst_pstrb", 64'(PSTRB), 64'd0);
        check("rst_done", 64'(req_done), 64'd0);
        check("rst_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_err", 64'(rsp_err), 64'd0);
        @(negedge PCLK);
        PRESETn = 1'b1;

        // req0 zero-wait write, then req1 read with three wait states
        set_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 0, 32'h0, 1'b0);
        single(0);
        set_req(1, 1'b0, 32'h20, $urandom, 3, 32'd25, 1'b0);
        single(1);

        // both held continuously: order 0,1,0,1 with an IDLE gap each time
        set_req(0, 1'b1, 32'h100, 32'h1111_0000, 0, $urandom, 1'b0);
        set_req(1, 1'b0, 32'h104, $urandom, 0, 32'h2222_0000, 1'b0);
        present(0);
        present(1);
        @(negedge PCLK);
        for (int t = 0; t < 4; t++) begin
            run_xfer(mdl_last ? 0 : 1);
            if (t == 2) release_req(0);
            if (t == 3) release_req(1);
            @(negedge PCLK);
        end
        idle_check();

        // watchdog: stuck PREADY, PREADY on the last cycle, one cycle earlier
        set_req(0, 1'b0, 32'h30, $urandom, 100, 32'hFFFF_FFFF, 1'b0);
        single(0);
        set_req(1, 1'b0, 32'h34, $urandom, TIMEOUT - 1, 32'hA5A5_A5A5, 1'b1);
        single(1);
        set_req(0, 1'b0, 32'h38, $urandom, TIMEOUT - 1, 32'h5A5A_5A5A, 1'b0);
        single(0);
        set_req(1, 1'b1, 32'h3C, $urandom, TIMEOUT - 2, $urandom, 1'b0);
        single(1);

        // slave error on a write, then a clean transfer
        set_req(1, 1'b1, 32'h40, 32'h0BAD_F00D, 1, $urandom, 1'b1);
        single(1);
        set_req(1, 1'b1, 32'h44, 32'h600D_F00D, 0, $urandom, 1'b0);
        single(1);

        // reset in the middle of ACCESS
        set_req(0, 1'b1, 32'h50, 32'hCAFE_0000, 10, 32'h0, 1'b0);
        present(0);
        @(negedge PCLK);
        @(negedge PCLK);
        PREADY = 1'b0;
        @(negedge PCLK);
        check("pre_rst_penable", 64'(PENABLE), 64'd1);
        #2;
        PRESETn = 1'b0;
        #1;
        check("midrst_psel", 64'(PSEL), 64'd0);
        check("midrst_penable", 64'(PENABLE), 64'd0);
        check("midrst_pstrb", 64'(PSTRB), 64'd0);
        check("midrst_done", 64'(req_done), 64'd0);
        mdl_last = 1'b1;
        last_rsp = '0;
        set_req(0, 1'b0, 32'h60, $urandom, 1, 32'h1234_5678, 1'b0);
        set_req(1, 1'b1, 32'h64, 32'h8765_4321, 0, $urandom, 1'b0);
        present(0);
        present(1);
        @(negedge PCLK);
        idle_check();
        PRESETn = 1'b1;
        @(negedge PCLK);
        run_xfer(0);
        release_req(0);
        @(negedge PCLK);
        run_xfer(1);
        release_req(1);
        @(negedge PCLK);
        idle_check();

        // randomized traffic, single and contending
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                rand_req(0);
                rand_req(1);
                pair_flow();
            end else begin
                int id;
                id = int'($urandom_range(0, 1));
                rand_req(id);
                single(id);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
